dm: RTL and testbench
=====================

# dm

Word-organised data memory for the MEM stage of the pipelined MIPS core. It performs synchronous stores with sw/sh/sb byte-lane merging, rejects misaligned stores, and keeps a sticky alignment-error flag and a store counter. The full read word goes out combinationally on DMRes, which feeds the load byte/halfword extension stage in the same cycle, ahead of the MEM/WB register.

## Interface
Parameters:
- DEPTH_LOG2, default 10: log2 of the word count (default 1024 words, 4 KiB).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset. Sampled only on the rising edge of clk.
- PC  input  32  PC of the instruction in MEM. Used only by the trace feature.
- Addr  input  32  byte address from the ALU.
- WD  input  32  store data, already forwarded.
- storeOp  input  2  store operation: 00 none, 01 sw, 10 sh, 11 sb.
- DMRes  output  32  word at mem[Addr[DEPTH_LOG2+1:2]], combinational.
- AlignErr  output  1  sticky flag for a misaligned store, registered.
- StoreCnt  output  16  count of committed stores, registered.

## Operation
- Word index is Addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap modulo the memory size.
- A store commits on the rising clk edge when reset is high and storeOp is not 00. Lane merging:
  - sw (Addr[1:0] must be 00): the whole word is replaced by WD.
  - sh (Addr[0] must be 0):
    - Addr[1]=0: bits [15:0] are replaced by WD[15:0].
    - Addr[1]=1: bits [31:16] are replaced by WD[15:0].
  - sb: byte Addr[1:0] (bits [8k+7:8k], k=Addr[1:0]) is replaced by WD[7:0].
  - In every case the other lanes keep their value.
- A misaligned sw or sh is handled as follows:
  - no memory bytes are written;
  - AlignErr is set to 1 at that edge and stays 1 until reset;
  - StoreCnt does not change.
- Each committed store increments StoreCnt by 1. StoreCnt wraps from 0xFFFF to 0x0000.
- Reads:
  - DMRes is valid in the same cycle Addr is valid.
  - It is independent of storeOp.
  - It never shows write data before the edge that commits it.

## Timing
- Reset behaviour (reset=0 at a rising edge):
  - every memory word becomes 0x00000000;
  - AlignErr becomes 0 and StoreCnt becomes 0;
  - a store presented in the same cycle is discarded.
- Outputs after reset: DMRes reads 0 for any address, AlignErr=0, StoreCnt=0.
- Store latency is 1 edge. A store at edge N is visible on DMRes for the same word from just after edge N.
- Read and write to the same word in the same cycle: DMRes shows the old value before the edge and the merged value after it. There is no internal bypass.
- Back-to-back stores to the same word in consecutive cycles merge cumulatively. For example, sb to lanes 0 then 1 leaves both bytes updated.
- If reset is asserted while a store is presented, reset wins.
- The block has no stall input and no handshake. Holding storeOp at 00 is the idle state.

## Configuration
- DM_TRACE_EN, when defined, adds a trace line for every committed store. The line is printed via $display at the commit edge in the form "<time>@<PC 8 hex>: *<word address 8 hex> <= <merged word 8 hex>".
  - The word address is {Addr[31:2],2'b00}.
  - The value printed is the full 32-bit word after merging.
  - Rejected (misaligned) stores print nothing.
- When DM_TRACE_EN is not defined, no trace logic and no $display statements are compiled in. Functional behaviour is identical either way.

## Test plan
- Reset check: hold reset=0 for 2 cycles with storeOp=01, Addr=0x10, WD=0xDEADBEEF. Required after release: DMRes(0x10)=0, AlignErr=0, StoreCnt=0.
- Sub-word merge:
  - sw Addr=0x20 WD=0x11223344.
  - Then sh Addr=0x22 WD=0x0000AABB.
  - Then sb Addr=0x21 WD=0x000000CC.
  - Required: DMRes(0x20)=0xAABBCC44 and StoreCnt=3.
- Misaligned stores:
  - sw Addr=0x31 WD=0xFFFFFFFF, then sh Addr=0x33.
  - Required: word 0x30 stays 0, AlignErr=1 from the first edge and stays 1, StoreCnt unchanged.
  - A later reset clears AlignErr.
- Read-during-write: with word 0x40=0x00000005, present sw Addr=0x40 WD=0x7.
  - Required: DMRes=0x5 before the edge and 0x7 after it.
- Wrap-around: sw Addr=0x00001004 WD=0x55 with DEPTH_LOG2=10. Required: DMRes(0x4)=0x55.
- Counter wrap and trace:
  - Preload StoreCnt=0xFFFF via 65535 stores, then do one more store. Required: StoreCnt=0x0000.
  - With DM_TRACE_EN defined: exactly one trace line per committed store, with the merged value.

Source files
------------

// File: rtl/dm.sv
// dm: word-organised data memory with sw/sh/sb lane merging, misaligned-store rejection, sticky AlignErr and store counter; optional DM_TRACE_EN store trace
module dm #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [1:0]  storeOp,
  output logic [31:0] DMRes,
  output logic        AlignErr,
  output logic [15:0] StoreCnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [31:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] old_w, wd_rep, merged_d;
  logic [3:0] be;
  logic misalign, commit, align_q, align_d;
  logic [15:0] cnt_q, cnt_d;
  logic unused_ok;
  assign idx = Addr[DEPTH_LOG2+1:2];
  assign unused_ok = ^{PC, Addr[31:DEPTH_LOG2+2]};
  // lane enables, replicated store data and the merged word for the addressed entry
  always_comb begin
    old_w    = mem_q[idx];
    misalign = (storeOp == 2'b01 && Addr[1:0] != 2'b00) || (storeOp == 2'b10 && Addr[0]);
    commit   = storeOp != 2'b00 && !misalign;
    be       = storeOp == 2'b01 ? 4'hF : storeOp == 2'b10 ? (Addr[1] ? 4'hC : 4'h3) : 4'b0001 << Addr[1:0];
    wd_rep   = storeOp == 2'b01 ? WD : storeOp == 2'b10 ? {2{WD[15:0]}} : {4{WD[7:0]}};
    for (int k = 0; k < 4; k++) merged_d[8*k +: 8] = be[k] ? wd_rep[8*k +: 8] : old_w[8*k +: 8];
    align_d  = align_q | misalign;
    cnt_d    = commit ? cnt_q + 16'd1 : cnt_q;
  end
  // memory, sticky error and counter state; reset clears everything and drops any store
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      align_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (commit) mem_q[idx] <= merged_d;
      align_q <= align_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef DM_TRACE_EN
  // one trace line per committed store showing the full merged word
  always_ff @(posedge clk) begin
    if (reset && commit) $display("%0t@%08h: *%08h <= %08h", $time, PC, {Addr[31:2], 2'b00}, merged_d);
  end
`endif
  assign DMRes    = old_w;
  assign AlignErr = align_q;
  assign StoreCnt = cnt_q;
endmodule

// File: tb/tb_dm.sv
// tb_dm: scoreboard bench for dm with directed vectors and a negedge monitor
module tb_dm;
  logic clk = 0, reset = 0;
  logic [31:0] PC = 0, Addr = 0, WD = 0, DMRes;
  logic [1:0] storeOp = 0;
  logic AlignErr;
  logic [15:0] StoreCnt;
  typedef struct { string nm; int kind; logic [31:0] v; } exp_t;
  exp_t q[$];
  int total = 0, passed = 0;
  dm #(.DEPTH_LOG2(10)) dut (.clk(clk), .reset(reset), .PC(PC), .Addr(Addr), .WD(WD),
    .storeOp(storeOp), .DMRes(DMRes), .AlignErr(AlignErr), .StoreCnt(StoreCnt));
  always #5 clk = ~clk;
  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input logic rst);
    @(posedge clk);
    #1;
    reset = rst; storeOp = op; Addr = a; WD = d; PC = PC + 4;
  endtask
  task automatic expect_v(input string nm, input int kind, input logic [31:0] v);
    exp_t e;
    e.nm = nm; e.kind = kind; e.v = v;
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        act = e.kind == 0 ? DMRes : e.kind == 1 ? {31'b0, AlignErr} : {16'b0, StoreCnt};
        total++;
        if (act !== e.v) $display("FAIL %s: got %08h expected %08h", e.nm, act, e.v);
        else passed++;
      end
    end
  end
  initial begin
    reset = 0; storeOp = 2'b01; Addr = 32'h10; WD = 32'hDEADBEEF;
    drive(2'b01, 32'h10, 32'hDEADBEEF, 0);
    drive(2'b01, 32'h10, 32'hDEADBEEF, 0);
    drive(2'b00, 32'h10, 0, 1);
    expect_v("rst_dmres", 0, 0); expect_v("rst_align", 1, 0); expect_v("rst_cnt", 2, 0);
    drive(2'b01, 32'h20, 32'h11223344, 1);
    drive(2'b00, 32'h20, 0, 1);
    expect_v("sw_word", 0, 32'h11223344); expect_v("sw_cnt", 2, 1);
    drive(2'b10, 32'h22, 32'h0000AABB, 1);
    drive(2'b00, 32'h20, 0, 1);
    expect_v("sh_hi", 0, 32'hAABB3344);
    drive(2'b11, 32'h21, 32'h000000CC, 1);
    drive(2'b00, 32'h20, 0, 1);
    expect_v("sb_lane1", 0, 32'hAABBCC44); expect_v("merge_cnt", 2, 3); expect_v("merge_align", 1, 0);
    drive(2'b10, 32'h24, 32'h1234BEEF, 1);
    drive(2'b00, 32'h24, 0, 1);
    expect_v("sh_lo", 0, 32'h0000BEEF);
    drive(2'b01, 32'h31, 32'hFFFFFFFF, 1);
    expect_v("mis_pre_align", 1, 0);
    drive(2'b10, 32'h33, 32'hFFFFFFFF, 1);
    expect_v("mis_sw_align", 1, 1); expect_v("mis_sw_cnt", 2, 4);
    drive(2'b00, 32'h30, 0, 1);
    expect_v("mis_word", 0, 0); expect_v("mis_sh_align", 1, 1); expect_v("mis_sh_cnt", 2, 4);
    drive(2'b11, 32'h33, 32'h00000012, 1);
    drive(2'b00, 32'h30, 0, 1);
    expect_v("sb_lane3", 0, 32'h12000000); expect_v("sb_cnt", 2, 5); expect_v("align_sticky", 1, 1);
    drive(2'b01, 32'h40, 32'h5, 1);
    drive(2'b01, 32'h40, 32'h7, 1);
    expect_v("rdw_before", 0, 32'h5);
    drive(2'b00, 32'h40, 0, 1);
    expect_v("rdw_after", 0, 32'h7);
    drive(2'b01, 32'h1004, 32'h55, 1);
    drive(2'b00, 32'h4, 0, 1);
    expect_v("wrap_addr", 0, 32'h55);
    drive(2'b11, 32'h50, 32'hA1, 1);
    drive(2'b11, 32'h51, 32'hB2, 1);
    drive(2'b00, 32'h50, 0, 1);
    expect_v("b2b_merge", 0, 32'h0000B2A1); expect_v("b2b_cnt", 2, 10);
    drive(2'b01, 32'h20, 32'h99, 0);
    drive(2'b00, 32'h20, 0, 1);
    expect_v("rst2_word", 0, 0); expect_v("rst2_align", 1, 0); expect_v("rst2_cnt", 2, 0);
    for (int i = 0; i < 65535; i++) drive(2'b11, 32'h60, i, 1);
    drive(2'b00, 32'h60, 0, 1);
    expect_v("cnt_ffff", 2, 32'hFFFF); expect_v("cnt_word", 0, 32'h000000FE);
    drive(2'b01, 32'h64, 32'h1, 1);
    drive(2'b00, 32'h64, 0, 1);
    expect_v("cnt_wrap", 2, 0); expect_v("cnt_wrap_word", 0, 1);
    @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
